// File: rtl/ci_pkg.sv
// Shared definitions for the custom-instruction initiator: FSM encodings and
// timeout defaults.
package ci_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;
  localparam int unsigned CNT_WIDTH              = 16;

  typedef logic [1:0] ci_state_t;

  localparam ci_state_t ST_IDLE  = 2'd0;
  localparam ci_state_t ST_ISSUE = 2'd1;
  localparam ci_state_t ST_WAIT  = 2'd2;
  localparam ci_state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/ci_initiator_counter.sv
// Generic synchronous up/down counter with enable; used for the initiator's
// done timeout.
module ci_initiator_counter #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          DIRECTION = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= DIRECTION ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ci_initiator.sv
// Custom-instruction bus initiator: accepts one client command, strobes it onto
// the OR-combined CI bus, waits for done (or times out) and returns the result.
module ci_initiator
  import ci_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [7:0]  reqCiN,
  input  logic [31:0] reqValueA,
  input  logic [31:0] reqValueB,
  output logic        start,
  output logic [7:0]  ciN,
  output logic [31:0] valueA,
  output logic [31:0] valueB,
  input  logic        done,
  input  logic [31:0] result,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respResult,
  output logic        respTimeout
);

  localparam logic [CNT_WIDTH-1:0] LP_LAST_COUNT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  ci_state_t             r_state;
  ci_state_t             w_state_next;
  logic [7:0]            r_ci_n;
  logic [31:0]           r_value_a;
  logic [31:0]           r_value_b;
  logic [31:0]           r_resp_result;
  logic                  r_resp_timeout;
  logic                  w_accept;
  logic                  w_active;
  logic                  w_timeout;
  logic                  w_cnt_reset;
  logic                  w_cnt_en;
  logic [CNT_WIDTH-1:0]  w_count;

  assign w_accept  = (r_state == ST_IDLE) && reqValid;
  assign w_active  = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  // done on the last counted cycle takes priority over the abort
  assign w_timeout = w_active && !done && (w_count == LP_LAST_COUNT);

  assign w_cnt_reset = reset || w_accept;
  assign w_cnt_en    = w_active && !done;

  ci_initiator_counter #(
    .WIDTH     (CNT_WIDTH),
    .DIRECTION (1'b1)
  ) u_timeout_cnt (
    .clock   (clock),
    .reset   (w_cnt_reset),
    .i_en    (w_cnt_en),
    .o_count (w_count)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (reqValid) w_state_next = ST_ISSUE;
      ST_ISSUE,
      ST_WAIT:  begin
        if (done || w_timeout) w_state_next = ST_RESP;
        else                   w_state_next = ST_WAIT;
      end
      ST_RESP:  if (respReady) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_ci_n         <= '0;
      r_value_a      <= '0;
      r_value_b      <= '0;
      r_resp_result  <= '0;
      r_resp_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_ci_n    <= reqCiN;
        r_value_a <= reqValueA;
        r_value_b <= reqValueB;
      end
      if (w_active && done) begin
        r_resp_result  <= result;
        r_resp_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_resp_result  <= '0;
        r_resp_timeout <= 1'b1;
      end
    end
  end

  // Bus outputs are forced to zero when idle so they never pollute the OR bus
  assign reqReady    = (r_state == ST_IDLE);
  assign start       = (r_state == ST_ISSUE);
  assign ciN         = w_active ? r_ci_n    : '0;
  assign valueA      = w_active ? r_value_a : '0;
  assign valueB      = w_active ? r_value_b : '0;
  assign respValid   = (r_state == ST_RESP);
  assign respResult  = r_resp_result;
  assign respTimeout = r_resp_timeout;

endmodule

// File: tb/tb_ci_initiator.sv
// Self-checking bench for ci_initiator: table of command vectors with a
// response scoreboard, plus reset/stray-done sequences.
module tb_ci_initiator;

  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic [7:0]  reqCiN;
  logic [31:0] reqValueA;
  logic [31:0] reqValueB;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;
  logic        respValid;
  logic        respReady;
  logic [31:0] respResult;
  logic        respTimeout;

  ci_initiator #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .reqCiN      (reqCiN),
    .reqValueA   (reqValueA),
    .reqValueB   (reqValueB),
    .start       (start),
    .ciN         (ciN),
    .valueA      (valueA),
    .valueB      (valueB),
    .done        (done),
    .result      (result),
    .respValid   (respValid),
    .respReady   (respReady),
    .respResult  (respResult),
    .respTimeout (respTimeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  ci_n;
    logic [31:0] a;
    logic [31:0] b;
    int          done_at;  // ISSUE/WAIT cycle index carrying done, -1 for none
    logic [31:0] res;
    int          bp;       // cycles of respReady=0 in RESP
    bit          stray;    // drive done during RESP
    logic [31:0] exp_res;
    logic        exp_to;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        to;
  } exp_t;

  vec_t vecs[8];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, 128'(reqReady), 128'(1'b1));
    check({name, "_bus"}, 128'({start, ciN, valueA, valueB}), 128'(0));
    check({name, "_resp"}, 128'({respValid, respResult, respTimeout}), 128'(0));
  endtask

  task automatic run_txn(input vec_t v);
    int   guard;
    int   n;
    exp_t e;
    guard = 0;
    while (!reqReady && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    check("req_ready_idle", 128'(reqReady), 128'(1'b1));
    reqValid  = 1'b1;
    reqCiN    = v.ci_n;
    reqValueA = v.a;
    reqValueB = v.b;
    sb_q.push_back('{v.exp_res, v.exp_to});
    @(negedge clock);
    // Scramble request inputs to prove the command is latched
    reqValid  = 1'b0;
    reqCiN    = ~v.ci_n;
    reqValueA = ~v.a;
    reqValueB = ~v.b;
    n = (v.done_at >= 0 && v.done_at < TO) ? v.done_at + 1 : TO;
    for (int k = 0; k < n; k++) begin
      check("start_pulse", 128'(start), 128'(k == 0));
      check("bus_hold", 128'({ciN, valueA, valueB}), 128'({v.ci_n, v.a, v.b}));
      check("busy_flags", 128'({reqReady, respValid}), 128'(0));
      if (k == v.done_at) begin
        done   = 1'b1;
        result = v.res;
      end
      @(negedge clock);
      done   = 1'b0;
      result = '0;
    end
    check("resp_latency", 128'(respValid), 128'(1'b1));
    e = sb_q.pop_front();
    for (int c = 0; c <= v.bp; c++) begin
      check("resp_valid", 128'(respValid), 128'(1'b1));
      check("resp_result", 128'(respResult), 128'(e.res));
      check("resp_timeout", 128'(respTimeout), 128'(e.to));
      check("resp_bus_zero", 128'({start, ciN, valueA, valueB}), 128'(0));
      check("resp_no_ready", 128'(reqReady), 128'(1'b0));
      if (c < v.bp) begin
        respReady = 1'b0;
        done      = v.stray;
        result    = v.stray ? 32'hFFFF_FFFF : 32'h0;
        @(negedge clock);
        done      = 1'b0;
        result    = '0;
      end
    end
    respReady = 1'b1;
    @(negedge clock);
    respReady = 1'b0;
    check("post_hs_valid", 128'(respValid), 128'(1'b0));
    check("post_hs_ready", 128'(reqReady), 128'(1'b1));
  endtask

  initial begin
    vecs[0] = '{8'h05, 32'h1, 32'h0, 0, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{8'h2A, 32'hCAFE_F00D, 32'h0BAD_F00D, 7, 32'h1234_5678, 0, 1'b0,
                32'h1234_5678, 1'b0};
    vecs[2] = '{8'hFF, 32'hFFFF_FFFF, 32'h8000_0001, -1, 32'h0, 2, 1'b1, 32'h0, 1'b1};
    vecs[3] = '{8'h11, 32'h0, 32'h5, 2, 32'hA5A5_A5A5, 5, 1'b1, 32'hA5A5_A5A5, 1'b0};
    vecs[4] = '{8'h33, 32'h3, 32'h4, TO - 1, 32'h0F0F_0F0F, 0, 1'b0, 32'h0F0F_0F0F, 1'b0};
    vecs[5] = '{8'h44, 32'h5, 32'h6, TO - 2, 32'h1357_9BDF, 1, 1'b0, 32'h1357_9BDF, 1'b0};
    vecs[6] = '{8'h55, 32'h7, 32'h8, TO, 32'h7777_7777, 0, 1'b0, 32'h0, 1'b1};
    vecs[7] = '{8'h00, 32'h0, 32'h0, 3, 32'h0, 0, 1'b0, 32'h0, 1'b0};

    reset     = 1'b1;
    reqValid  = 1'b0;
    reqCiN    = '0;
    reqValueA = '0;
    reqValueB = '0;
    done      = 1'b1;
    result    = 32'hFFFF_FFFF;
    respReady = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("in_reset");
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("after_reset");
    // Stray done in IDLE must not disturb anything
    repeat (2) @(negedge clock);
    check_reset_outputs("idle_stray_done");
    done   = 1'b0;
    result = '0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset while waiting for a responder, then a late done
    reqValid  = 1'b1;
    reqCiN    = 8'h77;
    reqValueA = 32'h1111_2222;
    reqValueB = 32'h3333_4444;
    @(negedge clock);
    reqValid = 1'b0;
    repeat (3) @(negedge clock);
    check("wait_state", 128'({start, ciN, valueA, valueB}),
          128'({1'b0, 8'h77, 32'h1111_2222, 32'h3333_4444}));
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("reset_in_wait");
    reset  = 1'b0;
    done   = 1'b1;
    result = 32'hDEAD_0001;
    repeat (3) begin
      @(negedge clock);
      check_reset_outputs("late_done");
    end
    done   = 1'b0;
    result = '0;
    check("sb_empty", 128'(sb_q.size()), 128'(0));

    run_txn(vecs[1]);
    check("sb_drained", 128'(sb_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
